// File: rtl/score_pkg.sv
// score_pkg: shared defaults, FSM state encoding and score limits for score_bin2bcd.
package score_pkg;

  localparam int BIN_W_DEFAULT  = 17;
  localparam int DIGITS_DEFAULT = 5;
  localparam int BCD_W          = 4 * DIGITS_DEFAULT;

  // Largest value representable in the given number of BCD digits (10^digits - 1).
  function automatic int score_max(input int digits);
    int v;
    v = 1;
    for (int i = 0; i < digits; i++) v = v * 10;
    return v - 1;
  endfunction

  localparam int MAX_SCORE = score_max(DIGITS_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/score_bin2bcd_digit_adj.sv
// bcd_digit_adj: one double-dabble correction cell, adds 3 to a BCD digit that is >= 5.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/score_bin2bcd.sv
// score_bin2bcd: sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
// Build option SCORE_SAT_EN: out-of-range scores display as all nines instead of wrapping.
module score_bin2bcd
  import score_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIN_W-1:0]      in_bin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_score,
  output logic                  out_valid,
  output logic                  overflow
);

  localparam int                OUT_W    = 4 * DIGITS;
  localparam int                CNT_W    = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);
  localparam logic [31:0]       MAX_U    = 32'(score_max(DIGITS));

  state_e             r_state;
  state_e             w_state_next;
  logic               w_done;
  logic [BIN_W-1:0]   r_bin;
  logic [OUT_W-1:0]   r_work;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_next;
  logic [OUT_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_out_valid;
  logic [OUT_W-1:0]   w_adj;
  logic [OUT_W-1:0]   w_work_shift;
  logic [OUT_W-1:0]   w_result;
  logic               w_accept;
  logic               w_in_over;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_work[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The top digit's carry falls off the end, so the result is in_bin mod 10^DIGITS.
  assign w_work_shift = {w_adj[OUT_W-2:0], r_bin[BIN_W-1]};
  assign w_in_over    = 32'(in_bin) > MAX_U;
  assign w_accept     = in_valid && in_ready;
  assign in_ready     = (r_state == IDLE);

`ifdef SCORE_SAT_EN
  localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{4'h9}};
  assign w_result = r_ovf_next ? ALL_NINES : w_work_shift;
`else
  assign w_result = w_work_shift;
`endif

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every output of this block is given a default first so no latch can be inferred.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_next = SHIFT;
      end
      SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bin       <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_ovf_next  <= 1'b0;
      r_bcd       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_bin      <= in_bin;
        r_work     <= '0;
        r_cnt      <= '0;
        r_ovf_next <= w_in_over;
      end else if (r_state == SHIFT) begin
        r_work <= w_work_shift;
        r_bin  <= {r_bin[BIN_W-2:0], 1'b0};
        r_cnt  <= r_cnt + CNT_W'(1);
        if (w_done) begin
          r_bcd       <= w_result;
          r_ovf       <= r_ovf_next;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign bcd_score = r_bcd;
  assign overflow  = r_ovf;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_score_bin2bcd.sv
// tb_score_bin2bcd: scoreboard bench; a decimal-arithmetic model predicts each conversion.
module tb_score_bin2bcd;

  localparam int BIN_W  = 17;
  localparam int DIGITS = 5;
  localparam int OUT_W  = 4 * DIGITS;

  typedef struct {
    logic [OUT_W-1:0] bcd;
    logic             ovf;
    int               acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [BIN_W-1:0]  in_bin = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [OUT_W-1:0]  bcd_score;
  logic              out_valid;
  logic              overflow;

  int                checks = 0;
  int                failures = 0;
  int                cyc = 0;
  exp_t              sb[$];
  logic [OUT_W-1:0]  held_bcd = '0;
  logic              held_ovf = 1'b0;

  score_bin2bcd #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bin    (in_bin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_score (bcd_score),
    .out_valid (out_valid),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits of the score modulo 10^DIGITS, saturated when the build asks.
  function automatic exp_t model(input int unsigned v, input int acc);
    exp_t        e;
    int unsigned lim;
    int unsigned m;
    lim = 1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 10;
    m     = v % lim;
    e.ovf = (v > lim - 1);
    e.acc = acc;
    e.bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      e.bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
`ifdef SCORE_SAT_EN
    if (e.ovf) e.bcd = {DIGITS{4'h9}};
`endif
    return e;
  endfunction

  task automatic send(input logic [BIN_W-1:0] v, input int junk_cycles);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      in_bin   = v;
      in_valid = 1'b1;
      @(posedge clk);
      #1 sb.push_back(model(32'(v), cyc));
      @(negedge clk);
      if (junk_cycles > 0) begin
        in_bin = 17'd7;
        repeat (junk_cycles) @(negedge clk);
      end
      in_valid = 1'b0;
      in_bin   = BIN_W'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Monitor: checks handshake, latency and the held result bus every cycle.
  initial begin
    exp_t it;
    logic exp_ready;
    forever begin
      @(negedge clk);
      #2;
      exp_ready = (sb.size() == 0) || (cyc >= sb[0].acc + BIN_W);
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          it = sb.pop_front();
          check("latency", 32'(cyc), 32'(it.acc + BIN_W));
          check("bcd_score", 32'(bcd_score), 32'(it.bcd));
          check("overflow", 32'(overflow), 32'(it.ovf));
          held_bcd = it.bcd;
          held_ovf = it.ovf;
        end
      end else begin
        check("bcd_hold", 32'(bcd_score), 32'(held_bcd));
        check("ovf_hold", 32'(overflow), 32'(held_ovf));
        if (sb.size() != 0 && cyc >= sb[0].acc + BIN_W) begin
          check("missing_out_valid", 32'(out_valid), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_bcd", 32'(bcd_score), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_overflow", 32'(overflow), 32'd0);

    send(17'd2048, 0);
    wait_idle();
    send(17'd99999, 0);
    send(17'd0, 0);
    wait_idle();
    send(17'd131071, 0);
    send(17'd100000, 0);
    wait_idle();
    send(17'd512, 10);
    wait_idle();

    // Asynchronous reset after the eighth shift of a conversion.
    send(17'd2048, 0);
    wait_idle();
    send(17'd4096, 0);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    held_bcd = '0;
    held_ovf = 1'b0;
    #1;
    check("midrst_bcd", 32'(bcd_score), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    send(17'd16, 0);
    wait_idle();

    for (int i = 0; i < 25; i++) begin
      send(BIN_W'($urandom_range(0, 131071)), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
